// File: rtl/gumnut_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone-style slave port between the Gumnut
// instruction-fetch master (M0) and data master (M1), with a slave watchdog.
module gumnut_bus_arbiter #(
    parameter int AW      = 12,
    parameter int DW      = 18,
    parameter int TIMEOUT = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,

    output logic [1:0]    gnt_o
);

    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WD_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic WD_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t        state_reg;
    logic          last_reg;     // 0 = M0 was last owner, 1 = M1
    logic [WW-1:0] wd_reg;
    logic [1:0]    gnt_reg;
    logic          m0_err_reg;
    logic          m1_err_reg;

    logic own0;
    logic own1;
    logic own_cyc;
    logic other_cyc;
    logic wd_expire;

    assign own0 = (state_reg == OWN0);
    assign own1 = (state_reg == OWN1);

    assign own_cyc   = own1 ? m1_cyc_i : m0_cyc_i;
    assign other_cyc = own1 ? m0_cyc_i : m1_cyc_i;

    // Ack on the last watchdog cycle takes precedence over the abort.
    assign wd_expire = WD_EN && s_stb_o && !s_ack_i && (wd_reg == WD_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            last_reg   <= 1'b1;
            wd_reg     <= '0;
            gnt_reg    <= 2'b00;
            m0_err_reg <= 1'b0;
            m1_err_reg <= 1'b0;
        end else begin
            m0_err_reg <= 1'b0;
            m1_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    wd_reg <= '0;
                    if (m0_cyc_i && (!m1_cyc_i || last_reg)) begin
                        state_reg <= OWN0;
                        gnt_reg   <= 2'b01;
                    end else if (m1_cyc_i) begin
                        state_reg <= OWN1;
                        gnt_reg   <= 2'b10;
                    end
                end
                OWN0, OWN1: begin
                    if (!own_cyc) begin
                        last_reg <= own1;
                        wd_reg   <= '0;
                        if (other_cyc) begin
                            state_reg <= own1 ? OWN0 : OWN1;
                            gnt_reg   <= own1 ? 2'b01 : 2'b10;
                        end else begin
                            state_reg <= IDLE;
                            gnt_reg   <= 2'b00;
                        end
                    end else if (wd_expire) begin
                        state_reg  <= ABORT;
                        gnt_reg    <= 2'b00;
                        last_reg   <= own1;
                        wd_reg     <= '0;
                        m0_err_reg <= own0;
                        m1_err_reg <= own1;
                    end else if (WD_EN && s_stb_o && !s_ack_i) begin
                        wd_reg <= wd_reg + WW'(1);
                    end else begin
                        wd_reg <= '0;
                    end
                end
                ABORT: begin
                    state_reg <= IDLE;
                    wd_reg    <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= 2'b00;
                    wd_reg    <= '0;
                end
            endcase
        end
    end

    // Slave side follows the owner combinationally; nothing leaks out in IDLE/ABORT.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (own0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (own1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    assign m0_ack_o = own0 && s_ack_i;
    assign m1_ack_o = own1 && s_ack_i;
    assign m0_dat_o = (own0 || own1) ? s_dat_i : '0;
    assign m1_dat_o = (own0 || own1) ? s_dat_i : '0;
    assign m0_err_o = m0_err_reg;
    assign m1_err_o = m1_err_reg;
    assign gnt_o    = gnt_reg;

endmodule

// File: tb/tb_gumnut_bus_arbiter.sv
// Directed bench for gumnut_bus_arbiter: stimulus pushes expected ack/err events,
// a negedge monitor pops and compares them; grant/slave-side values checked inline.
module tb_gumnut_bus_arbiter;

    localparam int AW = 12;
    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [AW-1:0] m0_adr = '0;
    logic [DW-1:0] m0_wdat = '0;
    logic [DW-1:0] m0_rdat;
    logic          m0_ack, m0_err;
    logic          m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [AW-1:0] m1_adr = '0;
    logic [DW-1:0] m1_wdat = '0;
    logic [DW-1:0] m1_rdat;
    logic          m1_ack, m1_err;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wdat;
    logic [DW-1:0] s_rdat = '0;
    logic          s_ack = 0;
    logic [1:0]    gnt;

    always #5 clk = ~clk;

    gumnut_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
        .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack),
        .gnt_o(gnt)
    );

    typedef struct {
        int          src;
        bit          is_err;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int src, input bit is_err, input logic [DW-1:0] dat);
        exp_t e;
        e.src = src;
        e.is_err = is_err;
        e.dat = dat;
        q.push_back(e);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic observe(input int src, input bit is_err, input logic [DW-1:0] dat);
        exp_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got src=%0d err=%0d dat=0x%0h expected none",
                     src, is_err, dat);
        end else begin
            e = q.pop_front();
            if (e.src != src || e.is_err != is_err || (!is_err && e.dat !== dat)) begin
                n_bad++;
                $display("FAIL bus_event: got src=%0d err=%0d dat=0x%0h expected src=%0d err=%0d dat=0x%0h",
                         src, is_err, dat, e.src, e.is_err, e.dat);
            end else begin
                $display("event src=%0d err=%0d dat=0x%0h ok", src, is_err, dat);
            end
        end
    endtask

    // Monitor: every ack/err the DUT presents must match the next expected event.
    initial begin
        forever begin
            @(negedge clk);
            if (m0_ack) observe(0, 1'b0, m0_rdat);
            if (m1_ack) observe(1, 1'b0, m1_rdat);
            if (m0_err) observe(0, 1'b1, '0);
            if (m1_err) observe(1, 1'b1, '0);
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_s_cyc", 32'(s_cyc), 32'h0);
        chk("rst_s_stb", 32'(s_stb), 32'h0);
        chk("rst_s_adr", 32'(s_adr), 32'h0);
        rst = 1'b0;

        // Single requester M0
        m0_cyc = 1; m0_stb = 1; m0_adr = 12'h123;
        chk("t1_gnt_t0", 32'(gnt), 32'h0);
        step;
        chk("t1_gnt_t1", 32'(gnt), 32'h1);
        chk("t1_s_cyc", 32'(s_cyc), 32'h1);
        chk("t1_s_stb", 32'(s_stb), 32'h1);
        chk("t1_s_adr", 32'(s_adr), 32'h123);
        step;
        step;
        s_ack = 1; s_rdat = 18'h2ABCD; push(0, 1'b0, 18'h2ABCD);
        step;
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        step;
        chk("t1_gnt_idle", 32'(gnt), 32'h0);

        // Simultaneous request after reset: M0 first, direct handoff, round-robin
        rst = 1'b1;
        step;
        rst = 1'b0;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; m1_adr = 12'h456;
        step;
        chk("t2_gnt_m0", 32'(gnt), 32'h1);
        chk("t2_s_adr_m0", 32'(s_adr), 32'h123);
        step;
        s_ack = 1; s_rdat = 18'h00011; push(0, 1'b0, 18'h00011);
        step;
        s_ack = 0;
        step;
        m0_cyc = 0; m0_stb = 0;
        chk("t2_gnt_hold", 32'(gnt), 32'h1);
        step;
        chk("t2_gnt_handoff", 32'(gnt), 32'h2);
        chk("t2_s_adr_m1", 32'(s_adr), 32'h456);
        s_ack = 1; s_rdat = 18'h3FFFF; push(1, 1'b0, 18'h3FFFF);
        step;
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        step;
        chk("t2_gnt_idle", 32'(gnt), 32'h0);
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        step;
        chk("t2_gnt_rr_m0", 32'(gnt), 32'h1);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        step;
        chk("t2_gnt_idle2", 32'(gnt), 32'h0);

        // Hold: M1 does three beats while M0 waits
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_wdat = 18'h1F0F0;
        step;
        chk("t3_gnt_m1", 32'(gnt), 32'h2);
        chk("t3_s_we", 32'(s_we), 32'h1);
        chk("t3_s_wdat", 32'(s_wdat), 32'h1F0F0);
        m0_cyc = 1; m0_stb = 1;
        for (int b = 0; b < 3; b++) begin
            s_ack = 1; s_rdat = 18'(18'h01000 + b); push(1, 1'b0, 18'(18'h01000 + b));
            step;
            s_ack = 0;
            chk("t3_gnt_held_a", 32'(gnt), 32'h2);
            step;
            chk("t3_gnt_held_b", 32'(gnt), 32'h2);
        end
        m1_cyc = 0; m1_stb = 0; m1_we = 0;
        step;
        chk("t3_gnt_m0_after", 32'(gnt), 32'h1);
        s_ack = 1; s_rdat = 18'h0ABCD; push(0, 1'b0, 18'h0ABCD);
        step;
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        step;
        chk("t3_gnt_idle", 32'(gnt), 32'h0);

        // Timeout: M1 strobes, slave never acks
        m1_cyc = 1; m1_stb = 1;
        step;
        chk("t4_gnt_m1", 32'(gnt), 32'h2);
        step;
        step;
        step;
        chk("t4_s_cyc_pre", 32'(s_cyc), 32'h1);
        step;
        push(1, 1'b1, '0);
        chk("t4_gnt_abort", 32'(gnt), 32'h0);
        chk("t4_s_cyc_abort", 32'(s_cyc), 32'h0);
        chk("t4_s_stb_abort", 32'(s_stb), 32'h0);
        m1_cyc = 0; m1_stb = 0;
        step;
        chk("t4_gnt_idle", 32'(gnt), 32'h0);

        // Ack on the final watchdog cycle
        m0_cyc = 1; m0_stb = 1;
        step;
        chk("t5_gnt_m0", 32'(gnt), 32'h1);
        step;
        step;
        step;
        s_ack = 1; s_rdat = 18'h15555; push(0, 1'b0, 18'h15555);
        step;
        s_ack = 0;
        chk("t5_gnt_no_abort", 32'(gnt), 32'h1);
        m0_cyc = 0; m0_stb = 0;
        step;
        chk("t5_gnt_idle", 32'(gnt), 32'h0);

        // Async reset mid-transfer while M0 owns
        m0_cyc = 1; m0_stb = 1;
        step;
        s_ack = 1; s_rdat = 18'h2AAAA;
        #1;
        chk("t6_s_cyc_pre", 32'(s_cyc), 32'h1);
        chk("t6_m0_ack_pre", 32'(m0_ack), 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_gnt_rst", 32'(gnt), 32'h0);
        chk("t6_s_cyc_rst", 32'(s_cyc), 32'h0);
        chk("t6_m0_ack_rst", 32'(m0_ack), 32'h0);
        chk("t6_m0_dat_rst", 32'(m0_rdat), 32'h0);
        s_ack = 0;
        m1_cyc = 1; m1_stb = 1;
        step;
        step;
        rst = 1'b0;
        step;
        chk("t6_gnt_prio_m0", 32'(gnt), 32'h1);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        step;
        step;
        chk("sb_drained", 32'(q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
